// File: rtl/enc8b10b_pkg.sv
// Shared constants and helpers for the 8b/10b encoder byte-rate path.
// Bitmasks are indexed by the sub-block value: a set bit marks a non-neutral code.
package enc8b10b_pkg;

    // Unbalanced 5b values: 0,1,2,4,8,15,16,23,24,27,29,30,31 (K.28 handled separately)
    localparam logic [31:0] UNBAL5_MASK = 32'hE981_8117;
    localparam logic [7:0]  UNBAL3_MASK = 8'h91;
    localparam logic [7:0]  K28_5       = 8'hBC;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    function automatic logic is_legal_k(input logic [7:0] b);
        return (b[4:0] == 5'd28) || (b == 8'hF7) || (b == 8'hFB) ||
               (b == 8'hFD) || (b == 8'hFE);
    endfunction

endpackage

// File: rtl/encoder_8b10b_rd_ctrl_rd_calc.sv
// Running-disparity step for one symbol: RD at the 6b and 4b boundaries and the RD after it.
// Purely combinational so the decoder-side checker can reuse it unchanged.
module rd_calc
    import enc8b10b_pkg::*;
(
    input  logic       rd_neg_i,
    input  logic [4:0] abcde_i,
    input  logic [2:0] fgh_i,
    input  logic       k_i,
    output logic       compls6_o,
    output logic       compls4_o,
    output logic       rd_neg_o
);

    logic unbal5;
    logic unbal3;
    logic rd6_neg;

    assign unbal5    = UNBAL5_MASK[abcde_i] | (k_i & (abcde_i == 5'd28));
    assign unbal3    = UNBAL3_MASK[fgh_i];
    assign rd6_neg   = rd_neg_i ^ unbal5;

    assign compls6_o = rd_neg_i;
    assign compls4_o = rd6_neg;
    assign rd_neg_o  = rd6_neg ^ unbal3;

endmodule

// File: rtl/encoder_8b10b_rd_ctrl.sv
// Byte-rate front end of the 8b/10b encoder: comma burst after reset, idle insertion,
// control-code legality checking and running-disparity tracking for the 5b6b/3b4b encoders.
module encoder_8b10b_rd_ctrl
    import enc8b10b_pkg::*;
#(
    parameter int INIT_COMMAS = 16,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 SBYTECLK,
    input  logic                 RESET_N,
    input  logic [7:0]           DIN,
    input  logic                 KIN,
    input  logic                 DIN_VALID,
    output logic                 DIN_READY,
    input  logic                 FORCE_RD_NEG,
    output logic                 A,
    output logic                 B,
    output logic                 C,
    output logic                 D,
    output logic                 E,
    output logic                 F,
    output logic                 G,
    output logic                 H,
    output logic                 K,
    output logic                 COMPLS6,
    output logic                 COMPLS4,
    output logic                 SYM_VALID,
    output logic                 IDLE_INS,
    output logic                 KERR,
    output logic [ERR_CNT_W-1:0] ERR_CNT
);

    localparam logic [7:0] LAST_COMMA = 8'(INIT_COMMAS - 1);

    state_e                 state_q, state_d;
    logic [7:0]             comma_cnt_q, comma_cnt_d;
    logic                   rd_neg_q, rd_neg_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic [7:0]             byte_q;
    logic                   k_q, compls6_q, compls4_q, sym_valid_q, idle_q, kerr_q;

    logic [7:0]             sel_byte;
    logic                   sel_k, sel_idle, sel_kerr;
    logic                   rd_start_neg, compls6_d, compls4_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d     = state_q;
        comma_cnt_d = comma_cnt_q;
        err_cnt_d   = err_cnt_q;
        sel_byte    = K28_5;
        sel_k       = 1'b1;
        sel_idle    = 1'b1;
        sel_kerr    = 1'b0;

        case (state_q)
            ST_INIT: begin
                comma_cnt_d = comma_cnt_q + 8'd1;
                if (comma_cnt_q == LAST_COMMA) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (DIN_VALID) begin
                    sel_byte = DIN;
                    sel_idle = 1'b0;
                    // An illegal control byte is passed on as data and flagged instead.
                    if (KIN && !is_legal_k(DIN)) begin
                        sel_k    = 1'b0;
                        sel_kerr = 1'b1;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                    end else begin
                        sel_k = KIN;
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    assign rd_start_neg = FORCE_RD_NEG | rd_neg_q;

    rd_calc u_rd_calc (
        .rd_neg_i  (rd_start_neg),
        .abcde_i   (sel_byte[4:0]),
        .fgh_i     (sel_byte[7:5]),
        .k_i       (sel_k),
        .compls6_o (compls6_d),
        .compls4_o (compls4_d),
        .rd_neg_o  (rd_neg_d)
    );

    // NOTE: reset is sampled on the clock edge, and all state uses non-blocking assignments.
    always_ff @(posedge SBYTECLK) begin
        if (!RESET_N) begin
            state_q     <= ST_INIT;
            comma_cnt_q <= 8'd0;
            rd_neg_q    <= 1'b1;
            err_cnt_q   <= '0;
            byte_q      <= 8'd0;
            k_q         <= 1'b0;
            compls6_q   <= 1'b0;
            compls4_q   <= 1'b0;
            sym_valid_q <= 1'b0;
            idle_q      <= 1'b0;
            kerr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            comma_cnt_q <= comma_cnt_d;
            rd_neg_q    <= rd_neg_d;
            err_cnt_q   <= err_cnt_d;
            byte_q      <= sel_byte;
            k_q         <= sel_k;
            compls6_q   <= compls6_d;
            compls4_q   <= compls4_d;
            sym_valid_q <= 1'b1;
            idle_q      <= sel_idle;
            kerr_q      <= sel_kerr;
        end
    end

    assign DIN_READY       = (state_q == ST_RUN);
    assign {E, D, C, B, A} = byte_q[4:0];
    assign {H, G, F}       = byte_q[7:5];
    assign K               = k_q;
    assign COMPLS6         = compls6_q;
    assign COMPLS4         = compls4_q;
    assign SYM_VALID       = sym_valid_q;
    assign IDLE_INS        = idle_q;
    assign KERR            = kerr_q;
    assign ERR_CNT         = err_cnt_q;

endmodule
